// File: rtl/aes_block_serializer_if.sv
// Block-in / word-out stream bundle around the AES block serializer.
// slave is the serializer's side; master is the surrounding pipeline driving blocks and draining words.
interface aes_block_serializer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_block_serializer.sv
// Purpose: buffers 128-bit AES result blocks and re-emits each as two 64-bit words, counting finished blocks.
// Latency: block accepted at edge T shows its first word in cycle T+1; one word per cycle sustained.
// Backpressure: in_ready drops only when DEPTH blocks are held; a slot freed by a pop is offered the next cycle.
module aes_block_serializer #(
    parameter int DEPTH    = 2,
    parameter bit LO_FIRST = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    aes_block_serializer_if.slave bus,
    input  logic                 swap_en_i,
    input  logic                 clear_i,
    output logic [CNT_W-1:0]     blk_cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [127:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    logic             push;
    logic             word_hs;
    logic             pop;
    logic [127:0]     head;
    logic [63:0]      word;
    logic [63:0]      word_out;

    // Readiness comes from registered occupancy only, so no out_ready -> in_ready path exists.
    assign bus.in_ready  = (count_q != FULL);
    assign bus.out_valid = (count_q != '0);
    assign bus.out_last  = bus.out_valid & half_q;

    assign push    = bus.in_valid & bus.in_ready & ~clear_i;
    assign word_hs = bus.out_valid & bus.out_ready;
    assign pop     = word_hs & half_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        half_d    = half_q;
        blk_cnt_d = blk_cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            half_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (word_hs) begin
                half_d = ~half_q;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            half_q    <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            half_q    <= half_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        word     = (half_q ^ ~LO_FIRST) ? head[127:64] : head[63:0];
        word_out = word;
        if (swap_en_i) begin
            for (int b = 0; b < 8; b++) begin
                word_out[8*b +: 8] = word[8*(7-b) +: 8];
            end
        end
    end

    assign bus.out_data = word_out;
    assign blk_cnt_o    = blk_cnt_q;

    // The second half of a block can only be selected while that block is still held.
    assert property (@(posedge clk_i) disable iff (!rst_n_i) !(half_q && (count_q == '0)));

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed and randomized bench for aes_block_serializer against a word-queue reference model.
module tb_aes_block_serializer;
    localparam int DEPTH    = 2;
    localparam bit LO_FIRST = 1'b1;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic             swap_en;
    logic             clear;
    logic [CNT_W-1:0] blk_cnt;

    aes_block_serializer_if bus();

    aes_block_serializer #(
        .DEPTH(DEPTH), .LO_FIRST(LO_FIRST), .CNT_W(CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .bus      (bus),
        .swap_en_i(swap_en),
        .clear_i  (clear),
        .blk_cnt_o(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: pending output words in emission order; bit 64 marks the second word of a block.
    logic [64:0]      wq[$];
    logic [CNT_W-1:0] exp_cnt;
    int               words_done;

    localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    function automatic logic [63:0] bswap(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
        return r;
    endfunction

    function automatic logic model_in_ready();
        return ((wq.size() + 1) / 2) < DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [127:0] d, input logic ordy, input logic clr);
        logic exp_vld, exp_rdy, do_push, do_pop;
        logic [63:0] exp_word;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        exp_vld = (wq.size() != 0);
        exp_rdy = model_in_ready();
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, exp_vld);
        chk("out_last", bus.out_last, exp_vld ? wq[0][64] : 1'b0);
        chk("blk_cnt", blk_cnt, exp_cnt);
        if (exp_vld) begin
            exp_word = swap_en ? bswap(wq[0][63:0]) : wq[0][63:0];
            chk("out_data", bus.out_data, exp_word);
        end
        do_push = iv && exp_rdy;
        do_pop  = exp_vld && ordy;
        @(posedge clk);
        if (clr) begin
            wq.delete();
        end else begin
            if (do_pop) begin
                if (wq[0][64]) exp_cnt++;
                words_done++;
                void'(wq.pop_front());
            end
            if (do_push) begin
                if (LO_FIRST) begin
                    wq.push_back({1'b0, d[63:0]});
                    wq.push_back({1'b1, d[127:64]});
                end else begin
                    wq.push_back({1'b0, d[127:64]});
                    wq.push_back({1'b1, d[63:0]});
                end
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        #2;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_blk_cnt", blk_cnt, '0);
        wq.delete();
        exp_cnt    = '0;
        words_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pend;
        logic         iv;
        int           sent;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        swap_en       = 1'b0;
        clear         = 1'b0;
        exp_cnt       = '0;
        words_done    = 0;
        repeat (3) @(posedge clk);

        // Reset and idle.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        // Single block, directed values.
        cycle(1'b1, BLK, 1'b1, 1'b0);
        settle();
        chk("single_w0", bus.out_data, 64'h8899AABBCCDDEEFF);
        chk("single_w0_last", bus.out_last, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        settle();
        chk("single_w1", bus.out_data, 64'h0011223344556677);
        chk("single_w1_last", bus.out_last, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        settle();
        chk("single_done_vld", bus.out_valid, 1'b0);
        chk("single_blk_cnt", blk_cnt, 4'd1);

        // Backpressure with a full buffer.
        do_reset();
        cycle(1'b1, 128'hA0A0_0000_0000_0001_A0A0_0000_0000_0000, 1'b0, 1'b0);
        cycle(1'b1, 128'hB1B1_0000_0000_0003_B1B1_0000_0000_0002, 1'b0, 1'b0);
        settle();
        chk("full_in_ready", bus.in_ready, 1'b0);
        pend = 128'hC2C2_0000_0000_0005_C2C2_0000_0000_0004;
        cycle(1'b1, pend, 1'b0, 1'b0);
        cycle(1'b1, pend, 1'b1, 1'b0);
        cycle(1'b1, pend, 1'b1, 1'b0);
        settle();
        chk("freed_in_ready", bus.in_ready, 1'b1);
        cycle(1'b1, pend, 1'b1, 1'b0);
        drain(6);
        chk("full_blk_cnt", blk_cnt, 4'd3);
        chk("full_words", words_done, 6);

        // Reset mid-block discards buffered data.
        cycle(1'b1, BLK, 1'b0, 1'b0);
        cycle(1'b1, ~BLK, 1'b1, 1'b0);
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Byte swap.
        swap_en = 1'b1;
        cycle(1'b1, BLK, 1'b0, 1'b0);
        settle();
        chk("swap_w0", bus.out_data, 64'hFFEEDDCCBBAA9988);
        drain(3);
        swap_en = 1'b0;

        // Clear in the middle of a block.
        do_reset();
        cycle(1'b1, 128'h1111_1111_1111_1111_2222_2222_2222_2222, 1'b0, 1'b0);
        cycle(1'b1, 128'h3333_3333_3333_3333_4444_4444_4444_4444, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 128'h5555_5555_5555_5555_6666_6666_6666_6666, 1'b1, 1'b1);
        settle();
        chk("clr_out_valid", bus.out_valid, 1'b0);
        chk("clr_in_ready", bus.in_ready, 1'b1);
        chk("clr_blk_cnt", blk_cnt, 4'd0);
        pend = 128'h7777_7777_7777_7777_8888_8888_8888_8888;
        cycle(1'b1, pend, 1'b0, 1'b0);
        settle();
        chk("clr_new_w0", bus.out_data, 64'h8888888888888888);
        chk("clr_new_last", bus.out_last, 1'b0);
        drain(3);

        // Randomized stream of 17 blocks across the counter wrap.
        do_reset();
        sent = 0;
        pend = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2000 && !(sent == 17 && wq.size() == 0); i++) begin
            iv = (sent < 17) && ($urandom_range(0, 1) == 1);
            if (iv && model_in_ready()) begin
                cycle(1'b1, pend, ($urandom_range(0, 3) != 0), 1'b0);
                sent++;
                pend = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                cycle(iv, pend, ($urandom_range(0, 3) != 0), 1'b0);
            end
        end
        settle();
        chk("wrap_complete", (sent == 17 && wq.size() == 0), 1'b1);
        chk("wrap_words", words_done, 34);
        chk("wrap_blk_cnt", blk_cnt, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Sits at the output end of the AES accelerator chain, after the stage-10 aes_top_wrapper, whose producer side emits 128-bit result blocks.
- Acts as the receiver for that stream: a valid/ready slave that buffers whole 128-bit blocks.
- Re-emits each block as two 64-bit words on a valid/ready master toward the cohort producer FIFO.
- Counts completed blocks for the uncached status path.

Parameters:
- DEPTH, 2, number of 128-bit block entries buffered; power of two, >= 2.
- LO_FIRST, 1, 1: emit bits [63:0] first, then [127:64]; 0: reverse order.
- CNT_W, 32, width of the completed-block counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  block valid from the last AES stage
- in_ready  output  1  serializer can accept a block
- in_data  input  128  ciphertext block
- out_valid  output  1  64-bit word valid
- out_ready  input  1  downstream accepts word
- out_data  output  64  current word
- out_last  output  1  current word is the second half of its block
- swap_en  input  1  reverse byte order within each 64-bit output word; static while out_valid is high
- clear  input  1  synchronous flush of buffered data
- blk_cnt  output  CNT_W  blocks fully emitted since reset

Behaviour:
- Clock, reset and handshake:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset: wr_ptr=0, rd_ptr=0, count=0, half=0, blk_cnt=0. Hence in_ready=1, out_valid=0, out_last=0; out_data is don't-care (bench reads it only when out_valid=1).
  - Reset asserted mid-block discards all buffered data; no partial word is emitted after release.
- Storage:
  - Circular buffer of DEPTH x 128 with pointers wr_ptr/rd_ptr (log2(DEPTH) bits, natural wrap) and count (0..DEPTH).
  - Register "half" selects which 64-bit word of the head entry is presented.
- Input side:
  - in_ready = (count != DEPTH). It is a function of registered state only and never depends on out_ready.
  - Push when in_valid & in_ready: write entry[wr_ptr], then wr_ptr++.
  - in_data must be held stable while in_valid=1 and in_ready=0. The block does not check this.
- Output side:
  - out_valid = (count != 0).
  - out_data = head entry, word selected by half and LO_FIRST (half=0 selects the first word), then byte-reversed when swap_en=1 (byte 0 <-> byte 7, and so on).
  - out_last = out_valid & half.
- Output handshake (out_valid & out_ready):
  - If half=0: half<=1.
  - If half=1: half<=0, rd_ptr++, the entry is popped, and blk_cnt<=blk_cnt+1, wrapping at 2^CNT_W.
- count update:
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle: unchanged.
  - When full (count=DEPTH), a pop in a cycle does not raise in_ready in that same cycle. The freed slot is visible the next cycle; there is no pass-through.
- Latency and throughput:
  - A block accepted at edge T appears on out_valid after edge T (first word visible in cycle T+1) when the buffer was empty.
  - Sustained throughput: one word per cycle, one block per two cycles. Input is never the bottleneck when DEPTH >= 2.
- clear (synchronous, highest priority over push/pop in the same cycle):
  - Next state: count=0, wr_ptr=rd_ptr=0, half=0.
  - blk_cnt is not modified.
  - A handshake occurring in the clear cycle is ignored: the word is not counted and the block is not stored.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_last hold, given swap_en is static.
- No FSM beyond the count/half state. Legal states:
  - EMPTY (count=0)
  - FIRST (count>0, half=0)
  - SECOND (count>0, half=1)
  - half=1 with count=0 is unreachable. Assert this in RTL.

Test Plan:
- Reset/idle: hold rst_n=0, then release, no stimulus -> in_ready=1, out_valid=0, out_last=0, blk_cnt=0 for 10 cycles.
- Single block, LO_FIRST=1, out_ready=1: push in_data=0x00112233_44556677_8899AABB_CCDDEEFF at cycle T:
  - T+1: out_data=0x8899AABBCCDDEEFF, out_last=0.
  - T+2: out_data=0x0011223344556677, out_last=1.
  - T+3: out_valid=0, blk_cnt=1.
- Backpressure/full, DEPTH=2: push 3 blocks back-to-back with out_ready=0 -> in_ready=0 after the second accept; the third is held. Raise out_ready -> 6 words in order, the third block accepted the cycle after the first pop, blk_cnt=3.
- swap_en=1 with the block above -> first word 0xFFEEDDCCBBAA9988.
- clear mid-block: push 2 blocks, consume one word, assert clear for 1 cycle -> next cycle out_valid=0, count=0, in_ready=1, blk_cnt unchanged (0). A new block then emits its first word first.
- Counter wrap, CNT_W=4: stream 17 blocks with random out_ready/in_valid -> blk_cnt=1. Scoreboard matches all 34 words.
